// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
// Shared definitions for the PS/2 host-to-device transmitter:
//   - FSM state encoding (state_t)
//   - err_code values
//   - frame length and default timing constants (65 MHz system clock)
//   - odd-parity helper used when a command byte is accepted
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    // Device clock falls in SEND: 8 data bits, parity, stop.
    localparam int BIT_COUNT = 10;

    localparam int DEF_INHIBIT_CYCLES = 6500;    // 100 us
    localparam int DEF_SETUP_CYCLES   = 325;     // 5 us
    localparam int DEF_TIMEOUT_CYCLES = 130000;  // 2 ms
    localparam int DEF_FILTER_LEN     = 8;

    localparam int TIMER_W = 18;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Conditions one raw PS/2 pad level: 2-flop synchroniser, then a filter
// whose output only follows the synchronised input after FILTER_LEN
// consecutive samples that differ from the current filtered level.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-low reset
//   raw   in  raw pad level (asynchronous)
//   level out filtered line level (resets to 1 = released line)
//   fall  out one-cycle pulse when level goes 1 -> 0
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int CNT_W = $clog2(FILTER_LEN) + 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            fall   <= 1'b0;
            // Any sample that agrees with the current level restarts the
            // count, so short glitches never reach the output.
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level <= sync_q[1];
                cnt_q <= '0;
                fall  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED, 0xF4,
// 0xFF) to the keyboard over open-drain clock/data lines shared with the
// keyboard receiver. busy gates that receiver while a frame is in flight.
// Ports:
//   clk, rst              system clock, synchronous active-low reset
//   tx_data, tx_valid     command byte and send request
//   tx_ready              high when a byte can be accepted (state IDLE)
//   ps2_clk_in/data_in    raw pad levels
//   ps2_clk_oe/data_oe    1 = pull the line low
//   busy                  frame in progress
//   tx_done / tx_err      one-cycle completion pulses (never together)
//   err_code              01 timeout, 10 NACK; cleared on the next accept
//   state_dbg             current FSM state
//
// Handshake: a byte is taken on any cycle where tx_valid && tx_ready; the
// byte is latched then and tx_data may change afterwards. tx_valid while
// not ready is ignored (nothing is queued).
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic [2:0] state_dbg
);
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [3:0]         bit_idx_q;
    logic [8:0]         frame_q;      // {parity, data}, shifted out LSB first
    logic               data_oe_q;
    logic               nack_q;
    logic [1:0]         err_code_q;

    logic clk_level, clk_fall, data_level;
    logic accept, timed, timer_limit, timeout, clk_oe;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_data_in),
        .level (data_level),
        .fall  ()
    );

    assign accept      = tx_valid && (state_q == ST_IDLE);
    assign timed       = state_q inside {ST_SEND, ST_ACK, ST_WAIT_IDLE};
    assign timer_limit = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        clk_oe  = 1'b0;
        tx_done = 1'b0;
        tx_err  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                clk_oe = 1'b1;
                if (timer_q == TIMER_W'(INHIBIT_CYCLES - 1)) state_d = ST_START;
            end
            ST_START: begin
                clk_oe = 1'b1;
                if (timer_q == TIMER_W'(SETUP_CYCLES - 1)) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    if (bit_idx_q == 4'(BIT_COUNT - 1)) state_d = ST_ACK;
                end else if (timer_limit) begin
                    timeout = 1'b1;
                end
            end
            ST_ACK: begin
                if (clk_fall)         state_d = ST_WAIT_IDLE;
                else if (timer_limit) timeout = 1'b1;
            end
            ST_WAIT_IDLE: begin
                // Line release wins over a coincident timeout so only one
                // completion pulse is ever produced.
                if (clk_level && data_level) begin
                    state_d = ST_IDLE;
                    if (nack_q) tx_err  = 1'b1;
                    else        tx_done = 1'b1;
                end else if (timer_limit) begin
                    timeout = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d = ST_IDLE;
            tx_err  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '0;
            data_oe_q  <= 1'b0;
            nack_q     <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q <= state_d;

            // One timer serves every phase: it restarts on each state change
            // and, in the device-clocked phases, on every device clock fall.
            if (state_q == ST_IDLE || state_d != state_q || (timed && clk_fall))
                timer_q <= '0;
            else
                timer_q <= timer_q + 1'b1;

            if (accept) begin
                frame_q    <= {odd_parity(tx_data), tx_data};
                nack_q     <= 1'b0;
                err_code_q <= ERR_NONE;
            end

            // Start bit: data is pulled low before the clock is released.
            if (state_q == ST_INHIBIT && state_d == ST_START) data_oe_q <= 1'b1;
            if (state_q == ST_START && state_d == ST_SEND)    bit_idx_q <= '0;

            if (state_q == ST_SEND && clk_fall) begin
                bit_idx_q <= bit_idx_q + 1'b1;
                if (bit_idx_q == 4'(BIT_COUNT - 1)) begin
                    data_oe_q <= 1'b0;               // stop bit: release
                end else begin
                    data_oe_q <= ~frame_q[0];
                    frame_q   <= {1'b0, frame_q[8:1]};
                end
            end

            if (state_q == ST_ACK && clk_fall) nack_q <= data_level;

            if (timeout)     err_code_q <= ERR_TIMEOUT;
            else if (tx_err) err_code_q <= ERR_NACK;

            if (state_d == ST_IDLE) data_oe_q <= 1'b0;
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ps2_clk_oe  = clk_oe;
    assign ps2_data_oe = data_oe_q;
    assign err_code    = err_code_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a behavioural keyboard on the bus.
// Timing constants are scaled down so the whole run stays short; the
// device half-period is well above the line filter delay.
module tb_ps2_host_tx;
    localparam int INH   = 65;
    localparam int SETUP = 13;
    localparam int TO    = 1000;
    localparam int FL    = 8;
    localparam int HP    = 30;   // device clock half-period in system cycles

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       busy, tx_done, tx_err;
    logic [1:0] err_code;
    logic [2:0] state_dbg;

    // Device side of the open-drain bus.
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_code    (err_code),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [9:0] exp_frame_q[$];   // {stop, parity, data} as seen on the bus
    logic [3:0] exp_resp_q[$];    // {tx_done, tx_err, err_code after pulse}
    int n_checks = 0;
    int n_fail   = 0;
    int n_frames = 0;
    int acc_cyc  = 0;
    int last_pulse_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Completion monitor: pops an expected response on every pulse.
    initial begin : resp_monitor
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (tx_done || tx_err) begin
                last_pulse_cyc = cyc;
                if (exp_resp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got done=%0d err=%0d, expected no pulse", tx_done, tx_err);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("resp_kind", 32'({tx_done, tx_err}), 32'(e[3:2]));
                    @(negedge clk);
                    check("resp_err_code", 32'(err_code), 32'(e[1:0]));
                    check("resp_ready_after", 32'(tx_ready), 32'd1);
                end
            end
        end
    end

    // ---------------- device model ----------------
    int dev_mode   = 0;     // 0 = ack, 1 = nack, 2 = never clocks
    bit dev_glitch = 1'b0;
    bit dev_abort  = 1'b0;
    bit dev_active = 1'b0;
    int dev_falls  = 0;

    initial begin : device
        logic [9:0] cap;
        logic [9:0] ef;
        forever begin
            @(negedge clk);
            // Request-to-send: host has released clock and holds data low.
            if (ps2_data_oe && !ps2_clk_oe && dev_mode != 2) begin
                dev_active = 1'b1;
                dev_falls  = 0;
                cap        = '0;
                repeat (HP) @(negedge clk);
                for (int i = 1; i <= 11; i++) begin
                    if (dev_abort) break;
                    if (i == 11) begin
                        dev_data = (dev_mode == 1);
                        repeat (HP / 2) @(negedge clk);
                    end
                    dev_clk   = 1'b0;
                    dev_falls = i;
                    repeat (HP) @(negedge clk);
                    dev_clk = 1'b1;
                    if (i <= 10) cap[i-1] = ps2_data_in;
                    if (dev_glitch && i == 4) begin
                        repeat (HP / 2) @(negedge clk);
                        dev_clk = 1'b0;
                        repeat (3) @(negedge clk);
                        dev_clk = 1'b1;
                        repeat (HP / 2) @(negedge clk);
                    end else begin
                        repeat (HP) @(negedge clk);
                    end
                end
                dev_data = 1'b1;
                if (!dev_abort) begin
                    n_frames++;
                    if (exp_frame_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL bus_frame_unexpected: got 0x%0h, expected no frame", cap);
                    end else begin
                        ef = exp_frame_q.pop_front();
                        check("bus_frame", 32'(cap), 32'(ef));
                    end
                end
                dev_active = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic par, input bit push_frame,
                             input bit push_resp, input logic [3:0] resp, input bit measure);
        int g;
        int n;
        g = 0;
        while (!tx_ready && g < 5000) begin @(negedge clk); g++; end
        check("send_ready", 32'(tx_ready), 32'd1);
        if (push_frame) exp_frame_q.push_back({1'b1, par, d});
        if (push_resp)  exp_resp_q.push_back(resp);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
        if (measure) begin
            n = 0;
            while (ps2_clk_oe && !ps2_data_oe && n < 10000) begin n++; @(negedge clk); end
            check("inhibit_len", 32'(n), 32'(INH));
            n = 0;
            while (ps2_clk_oe && ps2_data_oe && n < 10000) begin n++; @(negedge clk); end
            check("setup_len", 32'(n), 32'(SETUP));
            check("send_entry_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
        end
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while ((!tx_ready || dev_active || exp_resp_q.size() != 0) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle_timeout: got busy after %0d cycles, expected idle", name, g);
        end
        repeat (20) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int g;
        repeat (4) @(negedge clk);
        check("rst_ready",    32'(tx_ready), 32'd1);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_lines",    32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("rst_pulses",   32'({tx_done, tx_err}), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_state",    32'(state_dbg), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0xF4 (0,0,1,0,1,1,1,1, parity 0), acked, with phase timing
        send_byte(8'hF4, 1'b0, 1'b1, 1'b1, 4'b10_00, 1'b1);
        wait_idle("f4");

        // 0x01 (parity 0), device NACKs
        dev_mode = 1;
        send_byte(8'h01, 1'b0, 1'b1, 1'b1, 4'b01_10, 1'b0);
        check("accept_keeps_nothing", 32'(err_code), 32'd0);
        wait_idle("nack");
        check("nack_err_code_hold", 32'(err_code), 32'b10);
        dev_mode = 0;

        // 0xFF, device silent: timeout
        dev_mode = 2;
        send_byte(8'hFF, 1'b1, 1'b0, 1'b1, 4'b01_01, 1'b0);
        check("accept_clears_err", 32'(err_code), 32'd0);
        wait_idle("timeout");
        check("timeout_latency", 32'(last_pulse_cyc - acc_cyc), 32'(INH + SETUP + TO - 1));
        check("timeout_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        dev_mode = 0;

        // 0xED aborted by reset after the 5th device clock fall
        dev_falls = 0;
        send_byte(8'hED, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
        g = 0;
        while (dev_falls < 5 && g < 5000) begin @(negedge clk); g++; end
        check("abort_reached_fall5", 32'(dev_falls >= 5), 32'd1);
        repeat (15) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        rst = 1'b1;
        dev_abort = 1'b1;
        g = 0;
        while (dev_active && g < 5000) begin @(negedge clk); g++; end
        dev_abort = 1'b0;
        repeat (40) @(negedge clk);

        // 0xED (parity 1) completes after the reset
        send_byte(8'hED, 1'b1, 1'b1, 1'b1, 4'b10_00, 1'b0);
        wait_idle("ed_after_reset");

        // 0xED with a 0xAA request while busy: only 0xED goes out
        send_byte(8'hED, 1'b1, 1'b1, 1'b1, 4'b10_00, 1'b0);
        repeat (200) @(negedge clk);
        check("busy_mid_frame",  32'(busy), 32'd1);
        check("ready_mid_frame", 32'(tx_ready), 32'd0);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle("busy_ignore");
        repeat (100) @(negedge clk);
        check("no_second_frame", 32'(busy), 32'd0);

        // 0x5A (parity 1) with a 3-cycle clock glitch during SEND
        dev_glitch = 1'b1;
        send_byte(8'h5A, 1'b1, 1'b1, 1'b1, 4'b10_00, 1'b0);
        wait_idle("glitch");
        dev_glitch = 1'b0;

        check("frames_seen",     32'(n_frames), 32'd5);
        check("frames_pending",  32'(exp_frame_q.size()), 32'd0);
        check("resps_pending",   32'(exp_resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1);
    end

endmodule
